repeat_gen: RTL and testbench

Streams every number in a closed range [lo_in, hi_in] whose decimal form is one digit group repeated exactly GROUP_COUNT_N times, such as 1212 or 123123 for GROUP_COUNT_N=2. It also accumulates the sum of the numbers it emits. It is the generator counterpart of group_count: group_count tests one number for the repeated-group property, and repeat_gen builds those numbers directly from a seed and a decimal multiplier. It sits between the range loader and downstream consumers or checkers in the day-2 datapath.

---
 rtl/aoc_pkg.sv | 35 +++
 rtl/repeat_gen_if.sv | 32 +++
 rtl/repeat_gen_get_digs.sv | 21 ++
 rtl/repeat_gen.sv | 182 ++++++++++++++++++
 tb/tb_repeat_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aoc_pkg.sv
// Shared definitions for the day-2 datapath: FSM state encoding, default
// widths, digit-count limit and a power-of-ten helper.
package aoc_pkg;

  localparam int DEF_DATA_WIDTH      = 40;
  localparam int DEF_LONG_DATA_WIDTH = 64;

  // Largest decimal digit count representable in a 64-bit value (10^19 fits).
  localparam int MAX_DIGS = 20;

  typedef logic [DEF_DATA_WIDTH-1:0]      data_t;
  typedef logic [DEF_LONG_DATA_WIDTH-1:0] long_t;
  typedef logic [7:0]                     dig_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BUILD,
    CALC,
    SCAN,
    NEXT,
    DONE
  } state_e;

  // 10^k as a 64-bit constant, used to build digit-count thresholds.
  function automatic long_t pow10_of(input int k);
    long_t p;
    p = long_t'(1);
    for (int i = 0; i < k; i++) begin
      p = p * long_t'(10);
    end
    return p;
  endfunction

endpackage

// File: rtl/repeat_gen_if.sv
// Request / stream bundle for repeat_gen: range request with busy/done,
// valid/ready number stream and the running sum.
interface repeat_gen_if
  import aoc_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LONG_DATA_WIDTH = DEF_LONG_DATA_WIDTH
);

  logic                       start;
  logic [DATA_WIDTH-1:0]      lo_in;
  logic [DATA_WIDTH-1:0]      hi_in;
  logic [DATA_WIDTH-1:0]      n_out;
  logic                       n_valid;
  logic                       n_ready;
  logic                       busy;
  logic                       done;
  logic [LONG_DATA_WIDTH-1:0] sum_out;

  // Requester / consumer side.
  modport master (
    output start, lo_in, hi_in, n_ready,
    input  n_out, n_valid, busy, done, sum_out
  );

  // Generator side.
  modport slave (
    input  start, lo_in, hi_in, n_ready,
    output n_out, n_valid, busy, done, sum_out
  );

endinterface

// File: rtl/repeat_gen_get_digs.sv
// get_digs: number of decimal digits of an unsigned value (0 counts as 1).
module get_digs
  import aoc_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output dig_t             digs
);

  // Each power of ten the value reaches adds one digit.
  always_comb begin
    digs = dig_t'(1);
    for (int i = 1; i < MAX_DIGS; i++) begin
      if (long_t'(value) >= pow10_of(i)) begin
        digs = dig_t'(i + 1);
      end
    end
  end

endmodule

// File: rtl/repeat_gen.sv
// repeat_gen: enumerates every number in [lo, hi] made of one decimal digit
// group repeated GROUP_COUNT_N times, built as seed * repunit multiplier,
// streams them over valid/ready and accumulates their sum.
module repeat_gen
  import aoc_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LONG_DATA_WIDTH = DEF_LONG_DATA_WIDTH,
  parameter int GROUP_COUNT_N   = 2
) (
  input logic         clock,
  input logic         reset_n,
  repeat_gen_if.slave bus
);

  localparam dig_t BUILD_LAST = dig_t'(GROUP_COUNT_N - 2);

  state_e                     state;
  logic [DATA_WIDTH-1:0]      lo_q;
  logic [DATA_WIDTH-1:0]      hi_q;
  dig_t                       l_lo;
  dig_t                       l_hi;
  dig_t                       g;
  dig_t                       build_cnt;
  logic [LONG_DATA_WIDTH-1:0] pow10;
  logic [LONG_DATA_WIDTH-1:0] prev_pow10;
  logic [LONG_DATA_WIDTH-1:0] mult_m;
  logic [LONG_DATA_WIDTH-1:0] seed;
  logic [LONG_DATA_WIDTH-1:0] cand;
  logic [LONG_DATA_WIDTH-1:0] sum_q;
  logic                       n_valid_q;
  logic                       busy_q;
  logic                       done_q;

  dig_t                       lo_digs;
  dig_t                       hi_digs;
  logic [LONG_DATA_WIDTH-1:0] lo_ext;
  logic [LONG_DATA_WIDTH-1:0] hi_ext;
  logic [LONG_DATA_WIDTH-1:0] mul_a;
  logic [LONG_DATA_WIDTH-1:0] mul_b;
  logic [LONG_DATA_WIDTH-1:0] product;
  logic [LONG_DATA_WIDTH-1:0] seed_inc;
  logic [LONG_DATA_WIDTH-1:0] cand_inc;
  dig_t                       g_next;
  logic [15:0]                gn_next;

  get_digs #(.WIDTH(DATA_WIDTH)) u_lo_digs (.value(lo_q), .digs(lo_digs));
  get_digs #(.WIDTH(DATA_WIDTH)) u_hi_digs (.value(hi_q), .digs(hi_digs));

  assign lo_ext   = LONG_DATA_WIDTH'(lo_q);
  assign hi_ext   = LONG_DATA_WIDTH'(hi_q);
  assign seed_inc = seed + LONG_DATA_WIDTH'(1);
  assign cand_inc = cand + mult_m;
  assign g_next   = g + dig_t'(1);
  assign gn_next  = 16'(g_next) * 16'(GROUP_COUNT_N);

  // Single shared multiplier: M*pow10 while building the repunit, seed*M in CALC.
  always_comb begin
    mul_a = mult_m;
    mul_b = pow10;
    if (state == CALC) begin
      mul_a = prev_pow10;
      mul_b = mult_m;
    end
  end

  assign product = mul_a * mul_b;

  // A candidate is presented only if its seed still has g digits and n lies in range.
  function automatic logic in_range(
    input logic [LONG_DATA_WIDTH-1:0] n,
    input logic [LONG_DATA_WIDTH-1:0] s,
    input logic [LONG_DATA_WIDTH-1:0] p,
    input logic [LONG_DATA_WIDTH-1:0] lo,
    input logic [LONG_DATA_WIDTH-1:0] hi
  );
    return (s != p) && (n >= lo) && (n <= hi);
  endfunction

  // Main sequencer: walks group lengths, builds M, scans seeds and handles the stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      l_lo       <= '0;
      l_hi       <= '0;
      g          <= '0;
      build_cnt  <= '0;
      pow10      <= '0;
      prev_pow10 <= '0;
      mult_m     <= '0;
      seed       <= '0;
      cand       <= '0;
      sum_q      <= '0;
      n_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lo_q      <= (bus.lo_in == '0) ? DATA_WIDTH'(1) : bus.lo_in;
            hi_q      <= bus.hi_in;
            sum_q     <= '0;
            n_valid_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          l_lo       <= lo_digs;
          l_hi       <= hi_digs;
          g          <= dig_t'(1);
          pow10      <= LONG_DATA_WIDTH'(10);
          prev_pow10 <= LONG_DATA_WIDTH'(1);
          mult_m     <= LONG_DATA_WIDTH'(1);
          build_cnt  <= '0;
          state      <= BUILD;
        end
        BUILD: begin
          mult_m <= product + LONG_DATA_WIDTH'(1);
          if (build_cnt == BUILD_LAST) begin
            state <= CALC;
          end else begin
            build_cnt <= build_cnt + dig_t'(1);
          end
        end
        CALC: begin
          seed      <= prev_pow10;
          cand      <= product;
          n_valid_q <= in_range(product, prev_pow10, pow10, lo_ext, hi_ext);
          state     <= SCAN;
        end
        SCAN: begin
          if (n_valid_q) begin
            if (bus.n_ready) begin
              sum_q     <= sum_q + cand;
              seed      <= seed_inc;
              cand      <= cand_inc;
              n_valid_q <= in_range(cand_inc, seed_inc, pow10, lo_ext, hi_ext);
            end
          end else if ((cand > hi_ext) || (seed == pow10)) begin
            state <= NEXT;
          end else begin
            seed      <= seed_inc;
            cand      <= cand_inc;
            n_valid_q <= in_range(cand_inc, seed_inc, pow10, lo_ext, hi_ext);
          end
        end
        NEXT: begin
          g          <= g_next;
          prev_pow10 <= pow10;
          pow10      <= (pow10 << 3) + (pow10 << 1);
          if (gn_next > 16'(l_hi)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (gn_next >= 16'(l_lo)) begin
            mult_m    <= LONG_DATA_WIDTH'(1);
            build_cnt <= '0;
            state     <= BUILD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.n_out   = cand[DATA_WIDTH-1:0];
  assign bus.n_valid = n_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_out = sum_q;

endmodule

// File: tb/tb_repeat_gen.sv
// Scoreboard bench for repeat_gen: expected numbers are queued per DUT and a
// monitor pops them on every accepted handshake.
module tb_repeat_gen;

  localparam int DW = 40;
  localparam int LW = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  repeat_gen_if #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW)) bus2 ();
  repeat_gen_if #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW)) bus3 ();

  repeat_gen #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW), .GROUP_COUNT_N(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2)
  );
  repeat_gen #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW), .GROUP_COUNT_N(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(bus3)
  );

  longint unsigned q2[$];
  longint unsigned q3[$];
  int              vec_count   = 0;
  int              miscompares = 0;
  logic            held2       = 1'b0;
  logic            held3       = 1'b0;
  logic [DW-1:0]   held_val2   = '0;
  logic [DW-1:0]   held_val3   = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int sel, input longint unsigned v);
    if (sel == 3) q3.push_back(v);
    else          q2.push_back(v);
  endtask

  function automatic int qsize(input int sel);
    return (sel == 3) ? q3.size() : q2.size();
  endfunction

  task automatic driveBus(input int sel, input logic st, input logic [DW-1:0] lo,
                          input logic [DW-1:0] hi, input logic rdy);
    if (sel == 3) begin
      bus3.start = st; bus3.lo_in = lo; bus3.hi_in = hi; bus3.n_ready = rdy;
    end else begin
      bus2.start = st; bus2.lo_in = lo; bus2.hi_in = hi; bus2.n_ready = rdy;
    end
  endtask

  task automatic sampleBus(input int sel, output logic v, output logic [DW-1:0] o,
                           output logic d, output logic b, output logic [LW-1:0] s);
    if (sel == 3) begin
      v = bus3.n_valid; o = bus3.n_out; d = bus3.done; b = bus3.busy; s = bus3.sum_out;
    end else begin
      v = bus2.n_valid; o = bus2.n_out; d = bus2.done; b = bus2.busy; s = bus2.sum_out;
    end
  endtask

  task automatic checkReset(input int sel);
    logic v, d, b;
    logic [DW-1:0] o;
    logic [LW-1:0] s;
    sampleBus(sel, v, o, d, b, s);
    checkOutput("reset_n_out", o, 0);
    checkOutput("reset_n_valid", v, 0);
    checkOutput("reset_busy", b, 0);
    checkOutput("reset_done", d, 0);
    checkOutput("reset_sum_out", s, 0);
  endtask

  // Monitor for the N=2 instance: pops on each handshake and checks stalls hold.
  always @(negedge clock) begin
    if (reset_n) begin
      if (held2) begin
        checkOutput("stall_valid2", bus2.n_valid, 1);
        checkOutput("stall_value2", bus2.n_out, held_val2);
      end
      if (bus2.n_valid && bus2.n_ready) begin
        if (q2.size() == 0) begin
          vec_count++;
          miscompares++;
          $display("[TB] FAIL unexpected2: got %0d, expected no emission", bus2.n_out);
        end else begin
          checkOutput("emit2", bus2.n_out, q2.pop_front());
        end
      end
      held2     = bus2.n_valid && !bus2.n_ready;
      held_val2 = bus2.n_out;
    end else begin
      held2 = 1'b0;
    end
  end

  // Monitor for the N=3 instance.
  always @(negedge clock) begin
    if (reset_n) begin
      if (held3) begin
        checkOutput("stall_valid3", bus3.n_valid, 1);
        checkOutput("stall_value3", bus3.n_out, held_val3);
      end
      if (bus3.n_valid && bus3.n_ready) begin
        if (q3.size() == 0) begin
          vec_count++;
          miscompares++;
          $display("[TB] FAIL unexpected3: got %0d, expected no emission", bus3.n_out);
        end else begin
          checkOutput("emit3", bus3.n_out, q3.pop_front());
        end
      end
      held3     = bus3.n_valid && !bus3.n_ready;
      held_val3 = bus3.n_out;
    end else begin
      held3 = 1'b0;
    end
  end

  // One full run: pulse start, optionally stall on one value, wait for done, check sum.
  task automatic applyStimulus(input int sel, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                               input logic [LW-1:0] exp_sum, input int exp_first,
                               input int max_cycles, input logic [DW-1:0] stall_val,
                               input int stall_cycles);
    int first_valid = -1;
    bit done_seen   = 1'b0;
    int stall_left  = stall_cycles;
    logic v, d, b;
    logic [DW-1:0] o;
    logic [LW-1:0] s;
    @(posedge clock); #1;
    driveBus(sel, 1'b1, lo, hi, 1'b1);
    for (int cyc = 0; cyc < max_cycles && !done_seen; cyc++) begin
      @(negedge clock);
      sampleBus(sel, v, o, d, b, s);
      if (v && first_valid < 0) first_valid = cyc;
      if (cyc == 1) checkOutput("busy_after_start", b, 1);
      if (d) begin
        done_seen = 1'b1;
        checkOutput("busy_at_done", b, 0);
        checkOutput("sum_out", s, exp_sum);
      end else begin
        @(posedge clock); #1;
        sampleBus(sel, v, o, d, b, s);
        if (stall_left > 0 && v && o == stall_val) begin
          stall_left--;
          driveBus(sel, 1'b0, lo, hi, 1'b0);
        end else begin
          driveBus(sel, 1'b0, lo, hi, 1'b1);
        end
      end
    end
    if (!done_seen) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", max_cycles);
    end else begin
      if (exp_first >= 0) checkOutput("first_valid_cycle", first_valid, exp_first);
      @(negedge clock);
      sampleBus(sel, v, o, d, b, s);
      checkOutput("done_one_cycle", d, 0);
      checkOutput("sum_hold", s, exp_sum);
    end
    checkOutput("queue_drained", qsize(sel), 0);
    @(posedge clock); #1;
    driveBus(sel, 1'b0, lo, hi, 1'b1);
  endtask

  initial begin
    bit seen;
    driveBus(2, 1'b0, '0, '0, 1'b1);
    driveBus(3, 1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    checkReset(2);
    checkReset(3);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Basic range, first n_valid in cycle 4.
    pushExp(2, 11); pushExp(2, 22);
    applyStimulus(2, 11, 22, 33, 4, 200, '0, 0);

    pushExp(2, 99);
    applyStimulus(2, 95, 115, 99, -1, 200, '0, 0);

    pushExp(2, 64'd1188511885);
    applyStimulus(2, 1188511880, 1188511890, 64'd1188511885, -1, 5000, '0, 0);

    pushExp(2, 1010);
    applyStimulus(2, 998, 1012, 1010, -1, 300, '0, 0);

    for (int k = 1; k <= 9; k++) pushExp(3, 111 * k);
    applyStimulus(3, 100, 1000, 4995, -1, 300, '0, 0);

    // Backpressure on 33 for three cycles.
    for (int k = 1; k <= 9; k++) pushExp(2, 11 * k);
    applyStimulus(2, 11, 99, 495, -1, 300, 33, 3);

    // Single-digit range: nothing can repeat.
    applyStimulus(2, 1, 9, 0, -1, 50, '0, 0);

    // Inverted range.
    applyStimulus(2, 50, 20, 0, -1, 100, '0, 0);

    // Reset while a candidate is being presented.
    @(posedge clock); #1;
    driveBus(2, 1'b1, 11, 99, 1'b0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(posedge clock); #1;
      driveBus(2, 1'b0, 11, 99, 1'b0);
      if (bus2.n_valid) seen = 1'b1;
    end
    if (!seen) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL scan_timeout: got no n_valid, expected one within 50 cycles");
    end
    reset_n = 1'b0;
    #1;
    checkReset(2);
    @(posedge clock); #1;
    checkReset(2);
    driveBus(2, 1'b0, 0, 0, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b1;

    pushExp(2, 11); pushExp(2, 22);
    applyStimulus(2, 11, 22, 33, -1, 200, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
